fir_seq_ctrl: RTL and testbench
===============================

FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_TAP, default 11, meaning the number of FIR taps and data-buffer entries.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the width of samples and RAM write data.
REQ-003 SHALL have port wb_clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port wb_rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port cfg_start, input, 1 bit: single-cycle start request.
REQ-006 SHALL have port cfg_len, input, 32 bits: number of samples to process, sampled on an accepted start.
REQ-007 SHALL have port ap_idle, output, 1 bit: controller is in IDLE.
REQ-008 SHALL have port ap_done, output, 1 bit: sticky completion flag.
REQ-009 SHALL have port ss_tvalid, input, 1 bit: input sample valid.
REQ-010 SHALL have port ss_tdata, input, DATA_W bits: input sample.
REQ-011 SHALL have port ss_tready, output, 1 bit: controller accepts the sample.
REQ-012 SHALL have port dram_we, output, 1 bit: data-buffer RAM write enable.
REQ-013 SHALL have port dram_addr, output, 4 bits: data-buffer RAM address.
REQ-014 SHALL have port dram_wdata, output, DATA_W bits: data-buffer RAM write data.
REQ-015 SHALL have port tram_addr, output, 4 bits: tap RAM read address.
REQ-016 SHALL have port mac_clr, output, 1 bit: clear the datapath accumulator.
REQ-017 SHALL have port mac_en, output, 1 bit: accumulate the current RAM read data (RAM read latency is 1 cycle).
REQ-018 SHALL have port sm_tvalid, output, 1 bit: the datapath result is valid.
REQ-019 SHALL have port sm_tready, input, 1 bit: the downstream consumer accepts the result.
REQ-020 SHALL have port sm_tlast, output, 1 bit: the result is for the final sample of the run.

Function
REQ-021 SHALL implement the states IDLE, INIT, LOAD, CALC, DRAIN, OUT.
REQ-022 SHALL, in IDLE on cfg_start with cfg_len>0, latch cfg_len, clear ap_done, clear the sample count and set head=0, then go to INIT.
REQ-023 SHALL, on cfg_start with cfg_len==0, set ap_done the next cycle, stay in IDLE, and generate no RAM or stream activity.
REQ-024 SHALL ignore cfg_start in any state other than IDLE.
REQ-025 SHALL, in INIT, write 0 to dram_addr 0..NUM_TAP-1 (one address per cycle, dram_we=1), then go to LOAD; INIT lasts NUM_TAP cycles.
REQ-026 SHALL, in LOAD, assert ss_tready=1.
REQ-027 SHALL, on the ss_tvalid handshake in LOAD, assert dram_we=1 with dram_addr=head, dram_wdata=ss_tdata and mac_clr=1, then go to CALC.
REQ-028 SHALL, while ss_tvalid=0 in LOAD, wait with no write and no mac_clr.
REQ-029 SHALL, in CALC cycle k (k=0..NUM_TAP-1), drive tram_addr=k and dram_addr=(head-k) mod NUM_TAP, then go to DRAIN after k=NUM_TAP-1.
REQ-030 SHALL assert mac_en in the cycle after each CALC address issue, i.e. in CALC k=1..NUM_TAP-1 and in DRAIN; exactly NUM_TAP mac_en cycles per sample.
REQ-031 SHALL, in DRAIN, advance head to (head+1) mod NUM_TAP, increment the sample count and go to OUT.
REQ-032 SHALL, in OUT, hold sm_tvalid=1 until sm_tready=1, with sm_tlast=1 iff the sample count equals the latched length.
REQ-033 SHALL, while in OUT, keep ss_tready=0 and mac_en=0.
REQ-034 SHALL, on the OUT handshake, go to LOAD if samples remain, otherwise go to IDLE and set ap_done=1.
REQ-035 SHALL hold ap_done until the next accepted cfg_start.
REQ-036 SHALL achieve a minimum per-sample latency of 1 (LOAD) + NUM_TAP (CALC) + 1 (DRAIN) + 1 (OUT) = 14 cycles at the default NUM_TAP.
REQ-037 SHALL drive ap_idle=1 exactly when the state is IDLE.
REQ-038 SHALL drive all strobes (dram_we, mac_clr, mac_en, ss_tready, sm_tvalid) low outside the states that assert them.

Reset
REQ-039 SHALL, while wb_rst_i=1 (asynchronously, in any state), force state=IDLE, ap_idle=1, head=0, sample count=0, and all other outputs to 0.
REQ-040 SHALL, when reset is asserted mid-run, abort the run with no ap_done and no pending output retained.

Verification
REQ-041 SHALL verify: cfg_len=3 with ss_tvalid=1 and sm_tready=1 -> 11 INIT writes of 0 to addresses 0..10, then 3 sm_tvalid pulses 14 cycles apart, sm_tlast only on the third, then ap_done=1 and ap_idle=1.
REQ-042 SHALL verify: on the second sample (head=1) -> CALC tram_addr 0..10 paired with dram_addr 1,0,10,9,...,2; mac_en high for exactly 11 cycles.
REQ-043 SHALL verify: sm_tready held low for 5 cycles in OUT -> sm_tvalid stays 1 for 6 cycles, with ss_tready=0 and mac_en=0 throughout.
REQ-044 SHALL verify: ss_tvalid low for 4 cycles in LOAD -> no dram_we and no mac_clr until ss_tvalid rises.
REQ-045 SHALL verify: cfg_len=0 -> ap_done=1 one cycle later with no dram_we; a cfg_start pulsed during CALC has no effect.
REQ-046 SHALL verify: wb_rst_i asserted in CALC -> outputs zero immediately; after release, ap_idle=1 and ap_done=0.

Source files
------------

// File: rtl/fir_seq_ctrl.sv
// Sequencer for a time-multiplexed FIR: clears the sample buffer, loads one
// sample at a time, walks NUM_TAP tap/data address pairs, then hands off the result.
module fir_seq_ctrl #(
   parameter int unsigned NUM_TAP = 11,
   parameter int unsigned DATA_W  = 32
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              cfg_start,
   input  logic [31:0]       cfg_len,
   output logic              ap_idle,
   output logic              ap_done,
   input  logic              ss_tvalid,
   input  logic [DATA_W-1:0] ss_tdata,
   output logic              ss_tready,
   output logic              dram_we,
   output logic [3:0]        dram_addr,
   output logic [DATA_W-1:0] dram_wdata,
   output logic [3:0]        tram_addr,
   output logic              mac_clr,
   output logic              mac_en,
   output logic              sm_tvalid,
   input  logic              sm_tready,
   output logic              sm_tlast
);

   localparam int unsigned ADDR_W = 4;
   localparam int unsigned SUM_W  = ADDR_W + 1;
   localparam int unsigned CNT_W  = 32;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_TAP - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_INIT, S_LOAD, S_CALC, S_DRAIN, S_OUT
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_idx;
   logic [ADDR_W-1:0]   r_head;
   logic [CNT_W-1:0]    r_len;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_done;

   logic [SUM_W-1:0]    w_diff;
   logic [ADDR_W-1:0]   w_rd_addr;
   logic [ADDR_W-1:0]   w_head_nxt;
   logic                w_last;

   // Circular buffer read pointer: (head - idx) mod NUM_TAP without a divider
   assign w_diff     = {1'b0, r_head} + SUM_W'(NUM_TAP) - {1'b0, r_idx};
   assign w_rd_addr  = (w_diff >= SUM_W'(NUM_TAP)) ? ADDR_W'(w_diff - SUM_W'(NUM_TAP))
                                                   : ADDR_W'(w_diff);
   assign w_head_nxt = (r_head == LAST_IDX) ? '0 : r_head + ADDR_W'(1);
   assign w_last     = (r_cnt == r_len);

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_head  <= '0;
         r_len   <= '0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cfg_start) begin
                  if (cfg_len != '0) begin
                     r_len   <= cfg_len;
                     r_done  <= 1'b0;
                     r_cnt   <= '0;
                     r_head  <= '0;
                     r_idx   <= '0;
                     r_state <= S_INIT;
                  end else begin
                     r_done  <= 1'b1;
                  end
               end
            end
            S_INIT: begin
               if (r_idx == LAST_IDX) begin
                  r_idx   <= '0;
                  r_state <= S_LOAD;
               end else begin
                  r_idx   <= r_idx + ADDR_W'(1);
               end
            end
            S_LOAD: begin
               if (ss_tvalid) begin
                  r_idx   <= '0;
                  r_state <= S_CALC;
               end
            end
            S_CALC: begin
               if (r_idx == LAST_IDX) begin
                  r_idx   <= '0;
                  r_state <= S_DRAIN;
               end else begin
                  r_idx   <= r_idx + ADDR_W'(1);
               end
            end
            S_DRAIN: begin
               r_head  <= w_head_nxt;
               r_cnt   <= r_cnt + CNT_W'(1);
               r_state <= S_OUT;
            end
            S_OUT: begin
               if (sm_tready) begin
                  if (w_last) begin
                     r_done  <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     r_state <= S_LOAD;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Strobes decode from registered state; the LOAD write follows the live handshake
   always_comb begin
      ap_idle    = (r_state == S_IDLE);
      ap_done    = r_done;
      ss_tready  = 1'b0;
      dram_we    = 1'b0;
      dram_addr  = '0;
      dram_wdata = '0;
      tram_addr  = '0;
      mac_clr    = 1'b0;
      mac_en     = 1'b0;
      sm_tvalid  = 1'b0;
      sm_tlast   = 1'b0;
      case (r_state)
         S_INIT: begin
            dram_we   = 1'b1;
            dram_addr = r_idx;
         end
         S_LOAD: begin
            ss_tready = 1'b1;
            if (ss_tvalid) begin
               dram_we    = 1'b1;
               dram_addr  = r_head;
               dram_wdata = ss_tdata;
               mac_clr    = 1'b1;
            end
         end
         S_CALC: begin
            tram_addr = r_idx;
            dram_addr = w_rd_addr;
            mac_en    = (r_idx != '0);
         end
         S_DRAIN: mac_en = 1'b1;
         S_OUT: begin
            sm_tvalid = 1'b1;
            sm_tlast  = w_last;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed/randomized bench for fir_seq_ctrl with a behavioural RAM+MAC model
// and a reference FIR computed directly from the sample history.
module tb_fir_seq_ctrl;

   localparam int N = 11;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_start;
   logic [31:0] cfg_len;
   logic        ap_idle, ap_done;
   logic        ss_tvalid;
   logic [31:0] ss_tdata;
   logic        ss_tready;
   logic        dram_we;
   logic [3:0]  dram_addr;
   logic [31:0] dram_wdata;
   logic [3:0]  tram_addr;
   logic        mac_clr, mac_en;
   logic        sm_tvalid, sm_tready, sm_tlast;

   int n_cmp  = 0;
   int n_fail = 0;

   fir_seq_ctrl #(.NUM_TAP(N), .DATA_W(32)) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .cfg_start (cfg_start),
      .cfg_len   (cfg_len),
      .ap_idle   (ap_idle),
      .ap_done   (ap_done),
      .ss_tvalid (ss_tvalid),
      .ss_tdata  (ss_tdata),
      .ss_tready (ss_tready),
      .dram_we   (dram_we),
      .dram_addr (dram_addr),
      .dram_wdata(dram_wdata),
      .tram_addr (tram_addr),
      .mac_clr   (mac_clr),
      .mac_en    (mac_en),
      .sm_tvalid (sm_tvalid),
      .sm_tready (sm_tready),
      .sm_tlast  (sm_tlast)
   );

   always #5 clk = ~clk;

   // Datapath model: data/tap RAMs with 1-cycle read latency feeding an accumulator
   logic [31:0] m_dram [16];
   logic [31:0] m_taps [16];
   logic [31:0] m_rd_d, m_rd_t, m_acc;

   always @(posedge clk) begin
      if (dram_we) m_dram[dram_addr] <= dram_wdata;
      m_rd_d <= m_dram[dram_addr];
      m_rd_t <= m_taps[tram_addr];
      if (mac_clr)     m_acc <= '0;
      else if (mac_en) m_acc <= m_acc + m_rd_d * m_rd_t;
   end

   function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endfunction

   // One complete run; vgap/rgap < 0 selects random stall lengths, poke pulses cfg_start in CALC
   task automatic run(input int len, input int vgap, input int rgap, input bit poke);
      int          head;
      int          g;
      int          mac_cnt;
      logic [31:0] y;
      logic [31:0] hist [$];
      head = 0;
      @(negedge clk);
      cfg_start = 1'b1;
      cfg_len   = 32'(len);
      #1 chk("idle_before_start", 32'(ap_idle), 1);
      @(negedge clk);
      cfg_start = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (i != 0) @(negedge clk);
         #1;
         chk("init_we",    32'(dram_we), 1);
         chk("init_addr",  32'(dram_addr), 32'(i));
         chk("init_wdata", dram_wdata, 0);
         chk("init_done_clr", 32'(ap_done), 0);
         chk("init_idle",  32'(ap_idle), 0);
      end
      for (int s = 0; s < len; s++) begin
         g = (vgap < 0) ? int'($urandom_range(0, 3)) : vgap;
         for (int j = 0; j < g; j++) begin
            @(negedge clk);
            ss_tvalid = 1'b0;
            #1;
            chk("load_wait_ready", 32'(ss_tready), 1);
            chk("load_wait_we",    32'(dram_we), 0);
            chk("load_wait_clr",   32'(mac_clr), 0);
         end
         @(negedge clk);
         ss_tvalid = 1'b1;
         ss_tdata  = 32'($urandom_range(0, 65535));
         hist.push_back(ss_tdata);
         #1;
         chk("load_ready", 32'(ss_tready), 1);
         chk("load_we",    32'(dram_we), 1);
         chk("load_addr",  32'(dram_addr), 32'(head));
         chk("load_wdata", dram_wdata, ss_tdata);
         chk("load_clr",   32'(mac_clr), 1);
         mac_cnt = 0;
         for (int k = 0; k < N; k++) begin
            @(negedge clk);
            ss_tvalid = 1'b0;
            cfg_start = poke && (k == 3);
            cfg_len   = 32'd0;
            #1;
            chk("calc_tram",  32'(tram_addr), 32'(k));
            chk("calc_dram",  32'(dram_addr), 32'((head - k + N) % N));
            chk("calc_mac_en", 32'(mac_en), 32'(k != 0));
            chk("calc_we",    32'(dram_we), 0);
            chk("calc_ready", 32'(ss_tready), 0);
            chk("calc_valid", 32'(sm_tvalid), 0);
            mac_cnt += int'(mac_en);
         end
         @(negedge clk);
         cfg_start = 1'b0;
         #1;
         chk("drain_mac_en", 32'(mac_en), 1);
         chk("drain_valid",  32'(sm_tvalid), 0);
         mac_cnt += int'(mac_en);
         chk("mac_en_count", 32'(mac_cnt), N);
         y = '0;
         for (int k = 0; k < N; k++)
            if (s - k >= 0) y += m_taps[k] * hist[s - k];
         g = (rgap < 0) ? int'($urandom_range(0, 3)) : rgap;
         for (int j = 0; j < g; j++) begin
            @(negedge clk);
            sm_tready = 1'b0;
            #1;
            chk("out_hold_valid",  32'(sm_tvalid), 1);
            chk("out_hold_ready",  32'(ss_tready), 0);
            chk("out_hold_mac_en", 32'(mac_en), 0);
            chk("out_hold_last",   32'(sm_tlast), 32'(s == len - 1));
         end
         @(negedge clk);
         sm_tready = 1'b1;
         #1;
         chk("out_valid",  32'(sm_tvalid), 1);
         chk("out_last",   32'(sm_tlast), 32'(s == len - 1));
         chk("out_fir",    m_acc, y);
         chk("out_done",   32'(ap_done), 0);
         head = (head + 1) % N;
      end
      @(negedge clk);
      sm_tready = 1'b0;
      #1;
      chk("end_done", 32'(ap_done), 1);
      chk("end_idle", 32'(ap_idle), 1);
      chk("end_valid", 32'(sm_tvalid), 0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) m_taps[i] = 32'($urandom_range(1, 255));
      rst       = 1'b1;
      cfg_start = 1'b0;
      cfg_len   = '0;
      ss_tvalid = 1'b0;
      ss_tdata  = '0;
      sm_tready = 1'b0;

      @(negedge clk);
      #1;
      chk("rst_idle",   32'(ap_idle), 1);
      chk("rst_done",   32'(ap_done), 0);
      chk("rst_we",     32'(dram_we), 0);
      chk("rst_addr",   32'(dram_addr), 0);
      chk("rst_tvalid", 32'(sm_tvalid), 0);
      chk("rst_ready",  32'(ss_tready), 0);
      @(negedge clk);
      rst = 1'b0;

      // Zero-length start: done next cycle, no RAM activity
      @(negedge clk);
      cfg_start = 1'b1;
      cfg_len   = 32'd0;
      #1 chk("zl_done_before", 32'(ap_done), 0);
      @(negedge clk);
      cfg_start = 1'b0;
      #1;
      chk("zl_done", 32'(ap_done), 1);
      chk("zl_idle", 32'(ap_idle), 1);
      repeat (3) begin
         @(negedge clk);
         #1;
         chk("zl_no_we",    32'(dram_we), 0);
         chk("zl_no_ready", 32'(ss_tready), 0);
         chk("zl_done_hold", 32'(ap_done), 1);
      end

      run(3, 0, 0, 1'b0);
      run(2, 4, 5, 1'b0);
      run(5, -1, -1, 1'b1);

      // Reset in the middle of CALC
      @(negedge clk);
      cfg_start = 1'b1;
      cfg_len   = 32'd2;
      @(negedge clk);
      cfg_start = 1'b0;
      repeat (N - 1) @(negedge clk);
      @(negedge clk);
      ss_tvalid = 1'b1;
      ss_tdata  = 32'h1234;
      #1 chk("mr_load_clr", 32'(mac_clr), 1);
      @(negedge clk);
      ss_tvalid = 1'b0;
      repeat (3) @(negedge clk);
      #1 chk("mr_calc_mac_en", 32'(mac_en), 1);
      rst = 1'b1;
      #1;
      chk("mr_idle",   32'(ap_idle), 1);
      chk("mr_done",   32'(ap_done), 0);
      chk("mr_mac_en", 32'(mac_en), 0);
      chk("mr_tram",   32'(tram_addr), 0);
      chk("mr_dram",   32'(dram_addr), 0);
      chk("mr_ready",  32'(ss_tready), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         #1;
         chk("mr_after_idle",  32'(ap_idle), 1);
         chk("mr_after_done",  32'(ap_done), 0);
         chk("mr_after_valid", 32'(sm_tvalid), 0);
         chk("mr_after_we",    32'(dram_we), 0);
      end

      run(4, -1, -1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
